// File: rtl/pixel_ram_arbiter.sv
// pixel_ram_arbiter: shares the single-port frame-buffer RAM between VGA
// scan-out reads and buffered CPU pixel writes. It also owns the scan address
// counter and the frame-done pulse.
// Optional build macro: PIXEL_ARB_WRITE_BYPASS_EN. When it is defined, a CPU
// write that arrives while the FIFO is empty and the slot is idle goes
// straight to RAM instead of being queued.
module pixel_ram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 65536,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pix_req,
  output logic [DATA_W-1:0] pixel,
  output logic              pixel_valid,
  output logic              frame_done,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]   LIMIT_C   = SC_W'(STARVE_LIMIT);

  typedef enum logic {OFF, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] scan_q, scan_d;
  logic              pend_q, pend_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              rd_vld_p1;

  logic fifo_empty, fifo_full, run, forced, rd, wr, byp, push;

  // Saturating increment of the starvation counter.
  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v >= LIMIT_C) ? LIMIT_C : v + SC_W'(1);
  endfunction

  // Scan address increment with wrap at the last pixel of the frame.
  function automatic logic [ADDR_W-1:0] next_scan(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  // Slot selection, RAM port drive and next-state logic.
  always_comb begin
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == DEPTH_C);
    cpu_wr_ready = !fifo_full;
    run          = (state_q == RUN);
    forced       = !fifo_empty && (starve_q >= LIMIT_C);
    rd           = !forced && run && (pend_q || pix_req);
    wr           = forced || (!rd && !fifo_empty);
    byp          = 1'b0;
`ifdef PIXEL_ARB_WRITE_BYPASS_EN
    byp          = !rd && !wr && fifo_empty && cpu_wr_req;
`endif
    push         = cpu_wr_req && !fifo_full && !byp;

    ram_addr  = scan_q;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    if (wr) begin
      ram_addr  = fifo_addr[rd_ptr_q];
      ram_wdata = fifo_data[rd_ptr_q];
      ram_wren  = 1'b1;
    end else if (byp) begin
      ram_addr  = cpu_wr_addr;
      ram_wdata = cpu_wr_data;
      ram_wren  = 1'b1;
    end
    frame_done = rd && (scan_q == LAST_ADDR);

    state_d = enable ? RUN : OFF;

    // A request that lands on a forced-write slot is parked; a request that
    // coincides with draining the parked one keeps the flag set.
    pend_d = pend_q;
    if (!run)        pend_d = 1'b0;
    else if (forced) pend_d = pend_q || pix_req;
    else if (rd)     pend_d = pend_q && pix_req;

    scan_d = scan_q;
    if (!run)    scan_d = '0;
    else if (rd) scan_d = next_scan(scan_q);

    starve_d = (fifo_empty || wr) ? '0 : sat_inc(starve_q);
  end

  // Control state: FSM, scan counter, skid flag, starvation and FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= OFF;
      scan_q   <= '0;
      pend_q   <= 1'b0;
      starve_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      scan_q   <= scan_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (wr)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !wr)      count_q <= count_q + CNT_W'(1);
      else if (!push && wr) count_q <= count_q - CNT_W'(1);
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= cpu_wr_addr;
      fifo_data[wr_ptr_q] <= cpu_wr_data;
    end
  end

  // p1: RAM data returns; the capture register then presents the pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_p1   <= 1'b0;
      pixel_valid <= 1'b0;
      pixel       <= '0;
    end else begin
      rd_vld_p1   <= rd;
      pixel_valid <= rd_vld_p1;
      if (rd_vld_p1) pixel <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter with a behavioural synchronous RAM
// preloaded with addr[7:0].
module tb_pixel_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        pix_req = 1'b0;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        frame_done;
  logic        cpu_wr_req = 1'b0;
  logic [15:0] cpu_wr_addr = '0;
  logic [7:0]  cpu_wr_data = '0;
  logic        cpu_wr_ready;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_wren;
  logic [7:0]  ram_rdata = '0;

  logic [7:0]  mem [65536];

  int checks = 0;
  int errors = 0;

  pixel_ram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pix_req      (pix_req),
    .pixel        (pixel),
    .pixel_valid  (pixel_valid),
    .frame_done   (frame_done),
    .cpu_wr_req   (cpu_wr_req),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wren     (ram_wren),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read-before-write, data one cycle after address.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en;
    logic        pr;
    logic        wreq;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic        e_wren;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_pv;
    logic [7:0]  e_pix;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic pr, input logic wreq,
                     input logic [15:0] wa, input logic [7:0] wd);
    @(posedge clk);
    #1;
    enable      = en;
    pix_req     = pr;
    cpu_wr_req  = wreq;
    cpu_wr_addr = wa;
    cpu_wr_data = wd;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pixel"}, pixel, 0);
    chk({tag, "_pixel_valid"}, pixel_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_wr_ready"}, cpu_wr_ready, 1);
    chk({tag, "_wren"}, ram_wren, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
  endtask

  task automatic read_one(input logic [15:0] exp_addr, input logic [7:0] exp_pix);
    int   lat;
    logic got;
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
    chk("rd_addr", ram_addr, exp_addr);
    chk("rd_wren", ram_wren, 0);
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 6 && !got; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
      if (pixel_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("rd_latency", lat, 2);
    chk("rd_pixel", pixel, exp_pix);
  endtask

  initial begin
    int          pv_cnt;
    int          idx;
    int          widx;
    logic        e_wren;
    logic        e_pv;
    int          fd_cnt;
    logic [15:0] fd_addr;
    logic [15:0] prev;
    logic        have_prev;
    logic        wrapped;
    logic        done;
    int          pix_cd;

    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];

    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0001, 8'h00, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0001, 8'h00, 1'b1, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0002, 8'h00, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0002, 8'h00, 1'b1, 8'h01};
`ifdef PIXEL_ARB_WRITE_BYPASS_EN
    tbl[6] = '{1'b1, 1'b0, 1'b1, 16'h0010, 8'hAA, 1'b1, 16'h0010, 8'hAA, 1'b0, 8'h01};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b1, 8'h02};
`else
    tbl[6] = '{1'b1, 1'b0, 1'b1, 16'h0010, 8'hAA, 1'b0, 16'h0003, 8'h00, 1'b0, 8'h01};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0010, 8'hAA, 1'b1, 8'h02};
`endif
    tbl[8] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b0, 8'h02};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_reset("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table: first reads, a queued write and its drain
    for (int r = 0; r < 9; r++) begin
      cyc(tbl[r].en, tbl[r].pr, tbl[r].wreq, tbl[r].wa, tbl[r].wd);
      chk($sformatf("t%0d_wren", r), ram_wren, tbl[r].e_wren);
      chk($sformatf("t%0d_addr", r), ram_addr, tbl[r].e_addr);
      chk($sformatf("t%0d_wdata", r), ram_wdata, tbl[r].e_wdata);
      chk($sformatf("t%0d_pv", r), pixel_valid, tbl[r].e_pv);
      chk($sformatf("t%0d_pixel", r), pixel, tbl[r].e_pix);
      chk($sformatf("t%0d_ready", r), cpu_wr_ready, 1);
      chk($sformatf("t%0d_fd", r), frame_done, 0);
    end

    // Scan 0x0003..0x0012; 0x0010 holds the written 0xAA
    for (int a = 3; a <= 16'h12; a++)
      read_one(a[15:0], (a == 16'h10) ? 8'hAA : a[7:0]);

    // FIFO full, forced write, skid read, in-order drain
    pv_cnt = 0;
    for (int k = 0; k < 18; k++) begin
      idx = (k < 4) ? k : 4;
      cyc(1'b1, k <= 10, k <= 10, 16'h0100 + idx[15:0], 8'h50 + idx[7:0]);
      if (k <= 10) chk($sformatf("b%0d_ready", k), cpu_wr_ready, (k <= 3) || (k == 10));
      e_wren = (k == 9) || (k >= 12 && k <= 15);
      chk($sformatf("b%0d_wren", k), ram_wren, e_wren);
      if (e_wren) begin
        widx = (k == 9) ? 0 : k - 11;
        chk($sformatf("b%0d_waddr", k), ram_addr, 16'h0100 + widx[15:0]);
        chk($sformatf("b%0d_wdata", k), ram_wdata, 8'h50 + widx[7:0]);
      end
      e_pv = (k >= 2 && k <= 10) || k == 12 || k == 13;
      chk($sformatf("b%0d_pv", k), pixel_valid, e_pv);
      if (pixel_valid) begin
        chk($sformatf("b%0d_pixel", k), pixel, 8'h13 + pv_cnt[7:0]);
        pv_cnt++;
      end
    end
    chk("b_pv_total", pv_cnt, 11);

    // Continuous scan through the frame end, wrap, and on to 0x1233
    fd_cnt = 0;
    fd_addr = '0;
    prev = '0;
    have_prev = 1'b0;
    wrapped = 1'b0;
    done = 1'b0;
    pix_cd = 0;
    for (int n = 0; n < 80000 && !done; n++) begin
      cyc(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
      if (pix_cd > 0) begin
        pix_cd--;
        if (pix_cd == 0) begin
          chk("last_pixel_valid", pixel_valid, 1);
          chk("last_pixel", pixel, 8'hFF);
        end
      end
      if (frame_done) begin
        fd_cnt++;
        fd_addr = ram_addr;
        pix_cd = 2;
      end
      if (have_prev && prev == 16'hFFFF) begin
        chk("wrap_addr", ram_addr, 0);
        wrapped = 1'b1;
      end
      prev = ram_addr;
      have_prev = 1'b1;
      if (wrapped && ram_addr == 16'h1233) done = 1'b1;
    end
    chk("sweep_done", done, 1);
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_addr", fd_addr, 16'hFFFF);

    // Drop enable at scan 0x1234 with the 0x1233 read in flight
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("drop_prev_pv", pixel_valid, 1);
    chk("drop_prev_pixel", pixel, 8'h32);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("drop_inflight_pv", pixel_valid, 1);
    chk("drop_inflight_pixel", pixel, 8'h33);
    chk("drop_wren", ram_wren, 0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("drop_pv_once", pixel_valid, 0);
    chk("drop_scan_zero", ram_addr, 0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    read_one(16'h0000, 8'h00);

    // Reset while three writes are queued behind a read stream
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b1, 16'h0200 + i[15:0], 8'hC0 + i[7:0]);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 8'h0);
    chk("pre_rst_wren", ram_wren, 0);
    #1;
    reset = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk);
    #1;
    enable = 1'b0;
    pix_req = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      chk($sformatf("post_rst%0d_wren", i), ram_wren, 0);
      chk($sformatf("post_rst%0d_ready", i), cpu_wr_ready, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
